// File: rtl/interrupt_controller.sv
// Bus-mapped interrupt controller: per-channel edge/level capture, mask, and a
// single prioritised request to the Cpu with an ack / end-of-interrupt handshake.
module interrupt_controller #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   interrupts,
  input  logic [1:0]            address_bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  input  logic                  cs,
  input  logic                  r,
  input  logic                  w,
  output logic                  irq,
  output logic [VEC_WIDTH-1:0]  irq_vector,
  input  logic                  ack
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  state_t                state;
  logic [CHANNELS-1:0]   pending;
  logic [CHANNELS-1:0]   mask;
  logic [CHANNELS-1:0]   mode;
  logic [CHANNELS-1:0]   in_q;

  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  eoi_c;
  logic                  req_drop_c;
  logic [CHANNELS-1:0]   cand_c;
  logic [CHANNELS-1:0]   set_c;
  logic [CHANNELS-1:0]   clr_c;
  logic [CHANNELS-1:0]   vec_onehot_c;
  logic [VEC_WIDTH-1:0]  winner_c;
  logic [DATA_WIDTH-1:0] status_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_bus_c;

  assign wr_en_c      = cs & w;
  assign rd_en_c      = cs & r & ~w;
  assign eoi_c        = wr_en_c && (address_bus == ADDR_STATUS);
  assign cand_c       = pending & mask;
  assign vec_onehot_c = CHANNELS'(1) << irq_vector;
  assign req_drop_c   = (cand_c & vec_onehot_c) == '0;
  assign unused_bus_c = ^data_bus;

  // Edge channels fire on a 0->1 transition, level channels whenever high.
  assign set_c = interrupts & (mode | ~in_q);

  always_comb begin
    clr_c = '0;
    if (wr_en_c && (address_bus == ADDR_PENDING)) clr_c = data_bus[CHANNELS-1:0];
    if ((state == REQ) && ack) clr_c = clr_c | vec_onehot_c;
  end

  // Highest set index wins.
  always_comb begin
    winner_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cand_c[i]) winner_c = VEC_WIDTH'(i);
    end
  end

  always_comb begin
    status_c                 = '0;
    status_c[DATA_WIDTH-1]   = (state == ACTIVE);
    status_c[DATA_WIDTH-2]   = irq;
    status_c[VEC_WIDTH-1:0]  = irq_vector;
  end

  always_comb begin
    rd_data_c = '0;
    case (address_bus)
      ADDR_PENDING: rd_data_c = DATA_WIDTH'(pending);
      ADDR_MASK:    rd_data_c = DATA_WIDTH'(mask);
      ADDR_MODE:    rd_data_c = DATA_WIDTH'(mode);
      default:      rd_data_c = status_c;
    endcase
  end

  assign data_bus = rd_en_c ? rd_data_c : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_vector <= '0;
      pending    <= '0;
      mask       <= '0;
      mode       <= '0;
      in_q       <= '0;
    end else begin
      in_q    <= interrupts;
      pending <= (pending & ~clr_c) | set_c;
      if (wr_en_c && (address_bus == ADDR_MASK)) mask <= data_bus[CHANNELS-1:0];
      if (wr_en_c && (address_bus == ADDR_MODE)) mode <= data_bus[CHANNELS-1:0];
      case (state)
        IDLE: begin
          if (cand_c != '0) begin
            state      <= REQ;
            irq        <= 1'b1;
            irq_vector <= winner_c;
          end
        end
        REQ: begin
          // Vector stays frozen until ack, or until software withdraws the request.
          if (ack) begin
            state <= ACTIVE;
            irq   <= 1'b0;
          end else if (req_drop_c) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_vector <= '0;
          end
        end
        ACTIVE: begin
          if (eoi_c) begin
            state      <= IDLE;
            irq_vector <= '0;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized checks of interrupt_controller against a behavioural model.
module tb_interrupt_controller;

  localparam int unsigned CH = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned VW = 3;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACT  = 2;

  logic          clk;
  logic          reset;
  logic [CH-1:0] interrupts;
  logic [1:0]    address_bus;
  tri1  [DW-1:0] data_bus;
  logic          cs;
  logic          r;
  logic          w;
  logic          irq;
  logic [VW-1:0] irq_vector;
  logic          ack;

  logic          tb_drv;
  logic [DW-1:0] tb_data;

  int errors;
  int checks;

  // Behavioural model state
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_mode;
  logic [7:0] m_inq;
  logic       m_irq;
  logic [2:0] m_vec;
  int         m_phase;

  assign data_bus = tb_drv ? tb_data : {DW{1'bz}};

  interrupt_controller #(.CHANNELS(CH), .DATA_WIDTH(DW), .VEC_WIDTH(VW)) dut (
    .clk        (clk),
    .reset      (reset),
    .interrupts (interrupts),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .cs         (cs),
    .r          (r),
    .w          (w),
    .irq        (irq),
    .irq_vector (irq_vector),
    .ack        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_inq = '0;
    m_irq = 1'b0; m_vec = '0; m_phase = P_IDLE;
  endtask

  function automatic logic [DW-1:0] m_reg(input logic [1:0] a);
    logic [DW-1:0] s;
    s = '0;
    case (a)
      2'd0: s = DW'(m_pend);
      2'd1: s = DW'(m_mask);
      2'd2: s = DW'(m_mode);
      default: begin
        s[15]  = (m_phase == P_ACT);
        s[14]  = m_irq;
        s[2:0] = m_vec;
      end
    endcase
    return s;
  endfunction

  // One clock edge of the controller, described from its rules.
  task automatic model_edge(input logic [7:0] ints, input logic wr, input logic [1:0] a,
                            input logic [15:0] d, input logic ak);
    logic [7:0] cand, setb, clrb;
    int win;
    cand = m_pend & m_mask;
    win = -1;
    for (int c = 0; c < CH; c++) if (cand[c]) win = c;
    setb = '0;
    clrb = '0;
    for (int c = 0; c < CH; c++) if (ints[c] && (m_mode[c] || !m_inq[c])) setb[c] = 1'b1;
    if (wr && a == 2'd0) clrb = d[7:0];
    if (m_phase == P_REQ && ak) clrb[m_vec] = 1'b1;
    if (m_phase == P_IDLE) begin
      if (win >= 0) begin m_phase = P_REQ; m_irq = 1'b1; m_vec = 3'(win); end
    end else if (m_phase == P_REQ) begin
      if (ak) begin m_phase = P_ACT; m_irq = 1'b0; end
      else if (!cand[m_vec]) begin m_phase = P_IDLE; m_irq = 1'b0; m_vec = '0; end
    end else if (wr && a == 2'd3) begin
      m_phase = P_IDLE; m_vec = '0;
    end
    m_pend = (m_pend & ~clrb) | setb;
    if (wr && a == 2'd1) m_mask = d[7:0];
    if (wr && a == 2'd2) m_mode = d[7:0];
    m_inq = ints;
  endtask

  task automatic cycle(input logic [7:0] ints, input logic wr, input logic [1:0] a,
                       input logic [15:0] d, input logic ak);
    @(negedge clk);
    interrupts = ints; cs = wr; w = wr; r = 1'b0; address_bus = a;
    tb_drv = wr; tb_data = d; ack = ak;
    @(posedge clk);
    model_edge(ints, wr, a, d, ak);
    #1;
    cs = 1'b0; w = 1'b0; tb_drv = 1'b0; ack = 1'b0;
    chk("irq", DW'(irq), DW'(m_irq));
    chk("irq_vector", DW'(irq_vector), DW'(m_vec));
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [DW-1:0] exp);
    cs = 1'b1; r = 1'b1; address_bus = a;
    #1;
    chk(tag, data_bus, exp);
    cs = 1'b0; r = 1'b0;
    #1;
    chk({tag, "_released"}, data_bus, {DW{1'b1}});
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; interrupts = '0; address_bus = '0; cs = 1'b0; r = 1'b0; w = 1'b0;
    ack = 1'b0; tb_drv = 1'b0; tb_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_irq", DW'(irq), 16'h0);
    chk("reset_vec", DW'(irq_vector), 16'h0);
    for (int i = 0; i < 4; i++) rd("reset_reg", 2'(i), 16'h0000);

    // Edge pulse on the top channel, ack, EOI
    cycle(8'h00, 1'b1, 2'd1, 16'h00FF, 1'b0);
    cycle(8'h80, 1'b0, 2'd0, 16'h0, 1'b0);
    rd("t1_pending", 2'd0, 16'h0080);
    chk("t1_irq_not_yet", DW'(irq), 16'h0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t1_irq", DW'(irq), 16'h1);
    chk("t1_vec", DW'(irq_vector), 16'h7);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    chk("t1_irq_after_ack", DW'(irq), 16'h0);
    rd("t1_pending_ack", 2'd0, 16'h0000);
    rd("t1_status_active", 2'd3, 16'h8007);
    cycle(8'h00, 1'b1, 2'd3, 16'h0, 1'b0);
    rd("t1_status_eoi", 2'd3, 16'h0000);

    // Two channels at once: higher first, lower after EOI
    cycle(8'h24, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t2_vec_first", DW'(irq_vector), 16'h5);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    cycle(8'h00, 1'b1, 2'd3, 16'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t2_irq_second", DW'(irq), 16'h1);
    chk("t2_vec_second", DW'(irq_vector), 16'h2);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    cycle(8'h00, 1'b1, 2'd3, 16'h0, 1'b0);

    // Masked request latches but stays silent until unmasked
    cycle(8'h00, 1'b1, 2'd1, 16'h0000, 1'b0);
    cycle(8'h08, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    rd("t3_pending", 2'd0, 16'h0008);
    chk("t3_masked_irq", DW'(irq), 16'h0);
    cycle(8'h00, 1'b1, 2'd1, 16'hFF08, 1'b0);
    rd("t3_mask_readback", 2'd1, 16'h0008);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t3_irq", DW'(irq), 16'h1);
    chk("t3_vec", DW'(irq_vector), 16'h3);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    cycle(8'h00, 1'b1, 2'd3, 16'h0, 1'b0);

    // Level channel held high survives ack
    cycle(8'h00, 1'b1, 2'd2, 16'h0001, 1'b0);
    cycle(8'h00, 1'b1, 2'd1, 16'h0001, 1'b0);
    cycle(8'h01, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(8'h01, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t4_irq", DW'(irq), 16'h1);
    cycle(8'h01, 1'b0, 2'd0, 16'h0, 1'b1);
    rd("t4_pending_held", 2'd0, 16'h0001);
    cycle(8'h01, 1'b1, 2'd3, 16'h0, 1'b0);
    cycle(8'h01, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t4_irq_reassert", DW'(irq), 16'h1);
    cycle(8'h00, 1'b1, 2'd0, 16'h0001, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t4_irq_dropped", DW'(irq), 16'h0);
    rd("t4_pending_clear", 2'd0, 16'h0000);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t4_irq_stays_low", DW'(irq), 16'h0);
    cycle(8'h00, 1'b1, 2'd2, 16'h0000, 1'b0);

    // Software withdrawal in REQ, then set-beats-clear
    cycle(8'h00, 1'b1, 2'd1, 16'h00FF, 1'b0);
    cycle(8'h10, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t5_vec", DW'(irq_vector), 16'h4);
    cycle(8'h00, 1'b1, 2'd0, 16'h0010, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t5_withdrawn", DW'(irq), 16'h0);
    rd("t5_status_idle", 2'd3, 16'h0000);
    cycle(8'h10, 1'b1, 2'd0, 16'h0010, 1'b0);
    rd("t5_set_wins", 2'd0, 16'h0010);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t5_irq_again", DW'(irq), 16'h1);

    // Reset while ACTIVE with pending work
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    cycle(8'h00, 1'b1, 2'd3, 16'h0, 1'b0);
    cycle(8'h3C, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t6_vec", DW'(irq_vector), 16'h5);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b1);
    cycle(8'h20, 1'b0, 2'd0, 16'h0, 1'b0);
    rd("t6_pending", 2'd0, 16'h003C);
    rd("t6_status", 2'd3, 16'h8005);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_irq", DW'(irq), 16'h0);
    chk("t6_rst_vec", DW'(irq_vector), 16'h0);
    chk("t6_rst_bus", data_bus, 16'hFFFF);
    for (int i = 0; i < 4; i++) rd("t6_rst_reg", 2'(i), 16'h0000);
    @(negedge clk);
    ack = 1'b1; interrupts = 8'hFF;
    @(posedge clk);
    #1;
    chk("t6_rst_ack_irq", DW'(irq), 16'h0);
    ack = 1'b0;
    @(negedge clk);
    interrupts = 8'h00;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rd("t6_post_reg", 2'(i), 16'h0000);
    cycle(8'h00, 1'b0, 2'd0, 16'h0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0]  ri;
      logic        rw;
      logic [1:0]  ra;
      logic [15:0] rdat;
      logic        rak;
      ri   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rw   = ($urandom_range(0, 5) == 0);
      ra   = 2'($urandom);
      rdat = 16'($urandom);
      rak  = ($urandom_range(0, 3) == 0);
      cycle(ri, rw, ra, rdat, rak);
      if ($urandom_range(0, 2) == 0) begin
        ra = 2'($urandom);
        rd("rand_rd", ra, m_reg(ra));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
